// File: rtl/train_dispatch_ctrl.sv
// Stack-siding sequencer: captures a carriage count and departure order, then issues one
// push/pop move per cycle until the order is dispatched or proves unreachable.
module train_dispatch_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] data,
    output logic       busy,
    output logic       out_valid,
    output logic       cmd,
    output logic [3:0] car,
    output logic       done,
    output logic       result
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StFin} state_e;

    state_e     state_q;
    logic [4:0] n_q;
    logic [4:0] idx_q;
    logic [4:0] idx_w_q;
    logic [4:0] sp_q;
    logic [4:0] next_q;
    logic [3:0] order_q [16];
    logic [3:0] stack_q [16];

    logic [3:0] t;
    logic [3:0] top;
    logic [4:0] sp_m1;
    logic [4:0] idx_w_p1;
    logic       can_pop;
    logic       can_push;

    always_comb begin
        t        = order_q[idx_q[3:0]];
        sp_m1    = sp_q - 5'd1;
        top      = stack_q[sp_m1[3:0]];
        idx_w_p1 = idx_w_q + 5'd1;
        can_pop  = (sp_q != 5'd0) && (top == t);
        can_push = (next_q <= n_q) && (next_q <= {1'b0, t});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            n_q       <= 5'd0;
            idx_q     <= 5'd0;
            idx_w_q   <= 5'd0;
            sp_q      <= 5'd0;
            next_q    <= 5'd0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            cmd       <= 1'b0;
            car       <= 4'd0;
            done      <= 1'b0;
            result    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            cmd       <= 1'b0;
            car       <= 4'd0;
            done      <= 1'b0;
            result    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        n_q     <= {1'b0, data};
                        idx_q   <= 5'd0;
                        idx_w_q <= 5'd0;
                        sp_q    <= 5'd0;
                        next_q  <= 5'd1;
                        busy    <= 1'b1;
                        // Short frames must read 0 for entries never written.
                        for (int i = 0; i < 16; i++) begin
                            order_q[i] <= 4'd0;
                        end
                        state_q <= (data == 4'd0) ? StRun : StLoad;
                    end
                end
                StLoad: begin
                    if (in_valid) begin
                        order_q[idx_w_q[3:0]] <= data;
                        idx_w_q               <= idx_w_p1;
                        if (idx_w_p1 == n_q) begin
                            state_q <= StRun;
                        end
                    end else begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (idx_q == n_q) begin
                        done    <= 1'b1;
                        result  <= 1'b1;
                        state_q <= StFin;
                    end else if (can_pop) begin
                        out_valid <= 1'b1;
                        cmd       <= 1'b1;
                        car       <= t;
                        idx_q     <= idx_q + 5'd1;
                        sp_q      <= sp_m1;
                    end else if (can_push) begin
                        out_valid            <= 1'b1;
                        cmd                  <= 1'b0;
                        car                  <= next_q[3:0];
                        stack_q[sp_q[3:0]]   <= next_q[3:0];
                        sp_q                 <= sp_q + 5'd1;
                        next_q               <= next_q + 5'd1;
                    end else begin
                        done    <= 1'b1;
                        result  <= 1'b0;
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_train_dispatch_ctrl.sv
// Scoreboard bench for train_dispatch_ctrl: directed frames push expected moves/done events,
// a negedge monitor pops and compares them including the cycle they appear in.
module tb_train_dispatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] data;
    logic       busy;
    logic       out_valid;
    logic       cmd;
    logic [3:0] car;
    logic       done;
    logic       result;

    train_dispatch_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data      (data),
        .busy      (busy),
        .out_valid (out_valid),
        .cmd       (cmd),
        .car       (car),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        bit       is_done;
        logic [4:0] mv;
        bit       res;
    } ev_t;

    ev_t        exp_q[$];
    logic [3:0] ord[$];
    logic [4:0] mv[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid || done) begin
                ev_t e;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_event", {cmd, car, done, result}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk(!(out_valid && done), "valid_and_done", {out_valid, done}, 32'h0);
                    chk(cyc == e.cyc, "event_cycle", cyc, e.cyc);
                    chk(done == e.is_done, "event_kind", done, e.is_done);
                    if (e.is_done) chk(result == e.res, "result", result, e.res);
                    else chk({cmd, car} == e.mv, "move", {cmd, car}, e.mv);
                end
            end
            if (!out_valid) chk({cmd, car} == 5'd0, "idle_cmd_car", {cmd, car}, 32'h0);
            if (!done) chk(result == 1'b0, "idle_result", result, 32'h0);
        end
    end

    task automatic send_frame(input int n, output int c);
        @(posedge clk); #1;
        in_valid = 1'b1;
        data     = n[3:0];
        c        = cyc;
        @(negedge clk);
        chk(busy === 1'b0, "busy_at_header", busy, 32'h0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            data = ord[i];
            c    = cyc;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        data     = 4'd0;
    endtask

    task automatic expect_frame(input int c, input bit res, input bit with_done, output int d);
        for (int k = 0; k < mv.size(); k++) begin
            exp_q.push_back('{cyc: c + 2 + k, is_done: 1'b0, mv: mv[k], res: 1'b0});
        end
        d = c + 2 + mv.size();
        if (with_done) exp_q.push_back('{cyc: d, is_done: 1'b1, mv: 5'd0, res: res});
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic finish_frame(input int d);
        wait_until(d);
        @(negedge clk);
        chk(busy === 1'b1, "busy_at_done", busy, 32'h1);
    endtask

    task automatic run_frame(input bit res);
        int c, d;
        send_frame(ord.size(), c);
        expect_frame(c, res, 1'b1, d);
        finish_frame(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, d;
        rst      = 1'b1;
        in_valid = 1'b0;
        data     = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk({busy, out_valid, cmd, car, done, result} == 9'd0, "reset_outputs",
            {busy, out_valid, cmd, car, done, result}, 32'h0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // In order: each carriage passes straight through the siding.
        ord = '{4'd1, 4'd2, 4'd3};
        mv  = '{5'h01, 5'h11, 5'h02, 5'h12, 5'h03, 5'h13};
        run_frame(1'b1);

        // Full reversal.
        ord = '{4'd3, 4'd2, 4'd1};
        mv  = '{5'h01, 5'h02, 5'h03, 5'h13, 5'h12, 5'h11};
        run_frame(1'b1);

        // Unreachable: 2 sits above 1 after popping 3.
        ord = '{4'd3, 4'd1, 4'd2};
        mv  = '{5'h01, 5'h02, 5'h03, 5'h13};
        run_frame(1'b0);

        // Maximum depth: 15 pushes then 15 pops.
        ord = {};
        mv  = {};
        for (int i = 15; i >= 1; i--) ord.push_back(i[3:0]);
        for (int i = 1; i <= 15; i++) mv.push_back({1'b0, i[3:0]});
        for (int i = 15; i >= 1; i--) mv.push_back({1'b1, i[3:0]});
        run_frame(1'b1);

        // Empty frame back-to-back.
        ord = {};
        mv  = {};
        run_frame(1'b1);

        // Stray in_valid during RUN must be ignored.
        ord = '{4'd2, 4'd1, 4'd4, 4'd3};
        mv  = '{5'h01, 5'h02, 5'h12, 5'h11, 5'h03, 5'h04, 5'h14, 5'h13};
        send_frame(4, c);
        expect_frame(c, 1'b1, 1'b1, d);
        @(posedge clk); #1;
        in_valid = 1'b1;
        data     = 4'hf;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data     = 4'd0;
        finish_frame(d);

        // Zero in the order is unreachable at the first evaluation.
        ord = '{4'd0};
        mv  = {};
        run_frame(1'b0);

        // Reset mid-frame after the third move; no done for the aborted frame.
        ord = '{4'd3, 4'd2, 4'd1, 4'd4, 4'd5};
        mv  = '{5'h01, 5'h02, 5'h03};
        send_frame(5, c);
        expect_frame(c, 1'b0, 1'b0, d);
        wait_until(c + 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk({busy, out_valid, cmd, car, done, result} == 9'd0, "outputs_after_rst",
            {busy, out_valid, cmd, car, done, result}, 32'h0);

        ord = '{4'd2, 4'd1};
        mv  = '{5'h01, 5'h02, 5'h12, 5'h11};
        run_frame(1'b1);

        repeat (4) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
